// File: rtl/tabela_scanner.sv
// Sweeps a 4-input combinational stage through every input vector and checks its truth table against a golden copy.
// Latency: each vector is held SETTLE+1 cycles; done pulses 2^N_IN*(SETTLE+1)+1 cycles after start is accepted.
// Backpressure: none; start is honoured only when idle, and results hold until the next accepted start.
module tabela_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 s_in,
    input  logic [2**N_IN-1:0]   expected,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_count,
    output logic                 match,
    output logic [N_IN-1:0]      first_err
);

    localparam int TW    = 2**N_IN;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, COMPARE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TW-1:0]      exp_q;
    logic               accept;
    logic [TW-1:0]      diff;
    logic [N_IN:0]      ones_nxt;
    logic [N_IN-1:0]    first_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    accept    = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt == '0 && vec == LAST) state_nxt = COMPARE;
            end
            COMPARE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reverse scan so the lowest mismatching index is the one left standing.
    always_comb begin
        diff      = table_out ^ exp_q;
        ones_nxt  = '0;
        first_nxt = '0;
        for (int i = 0; i < TW; i++) begin
            ones_nxt = ones_nxt + (N_IN+1)'(table_out[i]);
        end
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) first_nxt = N_IN'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_out  <= '0;
            ones_count <= '0;
            match      <= 1'b0;
            first_err  <= '0;
            cnt        <= '0;
            exp_q      <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy       <= 1'b1;
                vec        <= '0;
                cnt        <= CNT_W'(SETTLE);
                exp_q      <= expected;
                table_out  <= '0;
                ones_count <= '0;
                match      <= 1'b0;
                first_err  <= '0;
            end
            if (state == DRIVE) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    table_out[vec] <= s_in;
                    // Terminal vector stays put; the FSM moves on to COMPARE instead of wrapping.
                    if (vec != LAST) begin
                        vec <= vec + N_IN'(1);
                        cnt <= CNT_W'(SETTLE);
                    end
                end
            end
            if (state == COMPARE) begin
                ones_count <= ones_nxt;
                match      <= (diff == '0);
                first_err  <= first_nxt;
                done       <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tabela_scanner.sv
// Scoreboard bench: two scanners (SETTLE=1 around s=~x&w|y&z|x&~w, SETTLE=0 around trivial stages).
module tb_tabela_scanner;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        m;
        logic [3:0]  fe;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start0 = 1'b0;
    logic [15:0] expected1 = '0, expected0 = '0;
    logic        mode0 = 1'b0;
    logic [3:0]  vec1, vec0, fe1, fe0;
    logic        s1, s0, busy1, busy0, done1, done0, m1, m0;
    logic [15:0] tbl1, tbl0;
    logic [4:0]  ones1, ones0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_done1 = 1'b0, prev_done0 = 1'b0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s1 = (vec1[3] & ~vec1[1]) | (~vec1[3] & vec1[1]) | (vec1[2] & vec1[0]);
    assign s0 = mode0 ? 1'b1 : vec0[0];

    tabela_scanner #(.N_IN(4), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .vec(vec1), .s_in(s1),
        .expected(expected1), .busy(busy1), .done(done1), .table_out(tbl1),
        .ones_count(ones1), .match(m1), .first_err(fe1)
    );

    tabela_scanner #(.N_IN(4), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .vec(vec0), .s_in(s0),
        .expected(expected0), .busy(busy0), .done(done0), .table_out(tbl0),
        .ones_count(ones0), .match(m0), .first_err(fe0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done1) begin
            check("dut1_done_width", 32'(prev_done1), 32'd0);
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dut1_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_done_cycle", 32'(cyc), 32'(e1.cyc));
                check("dut1_table", 32'(tbl1), 32'(e1.tbl));
                check("dut1_ones", 32'(ones1), 32'(e1.ones));
                check("dut1_match", 32'(m1), 32'(e1.m));
                check("dut1_first_err", 32'(fe1), 32'(e1.fe));
                check("dut1_busy_at_done", 32'(busy1), 32'd0);
                check("dut1_vec_at_done", 32'(vec1), 32'hF);
            end
        end
        prev_done1 <= done1;
    end

    always @(negedge clk) begin
        if (done0) begin
            check("dut0_done_width", 32'(prev_done0), 32'd0);
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL dut0_unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
                e0 = q0.pop_front();
                check("dut0_done_cycle", 32'(cyc), 32'(e0.cyc));
                check("dut0_table", 32'(tbl0), 32'(e0.tbl));
                check("dut0_ones", 32'(ones0), 32'(e0.ones));
                check("dut0_match", 32'(m0), 32'(e0.m));
                check("dut0_first_err", 32'(fe0), 32'(e0.fe));
                check("dut0_busy_at_done", 32'(busy0), 32'd0);
            end
        end
        prev_done0 <= done0;
    end

    // Caller is at a negedge; start is accepted on the following posedge.
    task automatic push1(input logic [15:0] tbl, input logic [4:0] ones, input logic m,
                         input logic [3:0] fe, input int done_cyc);
        exp_t e;
        e.tbl = tbl; e.ones = ones; e.m = m; e.fe = fe; e.cyc = done_cyc;
        q1.push_back(e);
    endtask

    task automatic scan1(input logic [15:0] exp_in, input logic [4:0] ones, input logic m,
                         input logic [3:0] fe);
        start1 = 1'b1;
        expected1 = exp_in;
        push1(16'hB3EC, ones, m, fe, cyc + 1 + 33);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic scan0(input logic [15:0] exp_in, input logic [15:0] tbl, input logic [4:0] ones,
                         input logic m, input logic [3:0] fe);
        exp_t e;
        start0 = 1'b1;
        expected0 = exp_in;
        e.tbl = tbl; e.ones = ones; e.m = m; e.fe = fe; e.cyc = cyc + 1 + 17;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while ((q1.size() != 0 || q0.size() != 0) && left > 0) begin
            @(negedge clk);
            left--;
        end
        if (q1.size() != 0 || q0.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending results, required 0", q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_vec"}, 32'(vec1), 32'd0);
        check({tag, "_busy"}, 32'(busy1), 32'd0);
        check({tag, "_done"}, 32'(done1), 32'd0);
        check({tag, "_table"}, 32'(tbl1), 32'd0);
        check({tag, "_ones"}, 32'(ones1), 32'd0);
        check({tag, "_match"}, 32'(m1), 32'd0);
        check({tag, "_first_err"}, 32'(fe1), 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_idle1("reset1");
        check("reset0_busy", 32'(busy0), 32'd0);
        check("reset0_table", 32'(tbl0), 32'd0);
        check("reset0_ones", 32'(ones0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Golden table matches; then single-bit mismatches at bit 0 and bit 2.
        scan1(16'hB3EC, 5'd10, 1'b1, 4'd0);
        check("dut1_busy_after_start", 32'(busy1), 32'd1);
        drain(100);
        scan1(16'hB3ED, 5'd10, 1'b0, 4'd0);
        drain(100);
        scan1(16'hB3E8, 5'd10, 1'b0, 4'd2);
        drain(100);

        // SETTLE=0 scanner: s = z, then s = 1 (ones_count reaches 16).
        scan0(16'hAAAA, 16'hAAAA, 5'd8, 1'b1, 4'd0);
        drain(100);
        mode0 = 1'b1;
        scan0(16'hAAAA, 16'hFFFF, 5'd16, 1'b0, 4'd0);
        drain(100);

        // Reset at cycle 10 of a scan aborts it.
        scan1(16'hB3EC, 5'd10, 1'b1, 4'd0);
        repeat (9) @(negedge clk);
        check("dut1_busy_mid_scan", 32'(busy1), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        q1.delete();
        check_idle1("abort1");
        reset = 1'b0;
        @(negedge clk);
        scan1(16'hB3EC, 5'd10, 1'b1, 4'd0);
        drain(100);

        // Stray starts and a changed golden table mid-scan are ignored.
        scan1(16'hB3E8, 5'd10, 1'b0, 4'd2);
        repeat (4) @(negedge clk);
        start1 = 1'b1; expected1 = 16'h0000;
        @(negedge clk);
        start1 = 1'b0;
        repeat (14) @(negedge clk);
        start1 = 1'b1; expected1 = 16'hFFFF;
        @(negedge clk);
        start1 = 1'b0;
        drain(100);
        repeat (3) @(negedge clk);
        check("no_extra_scan_busy", 32'(busy1), 32'd0);

        // start held high: back-to-back scans, one idle cycle between done and busy.
        expected1 = 16'hB3EC;
        start1 = 1'b1;
        k = cyc + 1;
        push1(16'hB3EC, 5'd10, 1'b1, 4'd0, k + 33);
        push1(16'hB3EC, 5'd10, 1'b1, 4'd0, k + 67);
        push1(16'hB3EC, 5'd10, 1'b1, 4'd0, k + 101);
        repeat (80) @(negedge clk);
        start1 = 1'b0;
        drain(100);
        repeat (3) @(negedge clk);
        check("held_start_stops_busy", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
